// File: rtl/data_memory_lsu_if.sv
// data_memory_lsu_if: load/store request and response bundle for data_memory_lsu.
// The debug read signals exist only when DATA_MEMORY_DEBUG_PORT_EN is defined.
interface data_memory_lsu_if #(
  parameter int NB_DATA_BUS = 32,
  parameter int NB_ADDRESS  = 8
);
  logic                   i_r_en;
  logic [NB_ADDRESS-1:0]  i_r_addr;
  logic [1:0]             i_r_size;
  logic                   i_r_signed;
  logic                   i_w_en;
  logic [NB_ADDRESS-1:0]  i_w_addr;
  logic [1:0]             i_w_size;
  logic [NB_DATA_BUS-1:0] i_w_data;
  logic [NB_DATA_BUS-1:0] o_r_data;
  logic                   o_r_valid;
  logic                   o_misaligned;
  logic                   o_busy;
`ifdef DATA_MEMORY_DEBUG_PORT_EN
  logic                                           i_dbg_en;
  logic [NB_ADDRESS-$clog2(NB_DATA_BUS/8)-1:0]    i_dbg_addr;
  logic [NB_DATA_BUS-1:0]                         o_dbg_data;
  logic                                           o_dbg_valid;
  modport master (
    output i_r_en, i_r_addr, i_r_size, i_r_signed, i_w_en, i_w_addr, i_w_size, i_w_data, i_dbg_en, i_dbg_addr,
    input  o_r_data, o_r_valid, o_misaligned, o_busy, o_dbg_data, o_dbg_valid
  );
  modport slave (
    input  i_r_en, i_r_addr, i_r_size, i_r_signed, i_w_en, i_w_addr, i_w_size, i_w_data, i_dbg_en, i_dbg_addr,
    output o_r_data, o_r_valid, o_misaligned, o_busy, o_dbg_data, o_dbg_valid
  );
`else
  modport master (
    output i_r_en, i_r_addr, i_r_size, i_r_signed, i_w_en, i_w_addr, i_w_size, i_w_data,
    input  o_r_data, o_r_valid, o_misaligned, o_busy
  );
  modport slave (
    input  i_r_en, i_r_addr, i_r_size, i_r_signed, i_w_en, i_w_addr, i_w_size, i_w_data,
    output o_r_data, o_r_valid, o_misaligned, o_busy
  );
`endif
endinterface

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-enable data memory with registered, extended loads and a post-reset clear.
// Optional full-word debug read port enabled by defining DATA_MEMORY_DEBUG_PORT_EN.
module data_memory_lsu #(
  parameter int NB_DATA_BUS    = 32,
  parameter int N_WORDS        = 64,
  parameter int NB_ADDRESS     = $clog2(N_WORDS) + $clog2(NB_DATA_BUS/8),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  data_memory_lsu_if.slave  bus
);
  localparam int LANE_BITS = $clog2(NB_DATA_BUS/8);
  localparam int NB_BYTES  = NB_DATA_BUS/8;
  localparam int NB_IDX    = $clog2(N_WORDS);
  localparam logic [1:0] SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_DWORD = 2'b10, SZ_BYTE = 2'b11;
  typedef enum logic {CLEAR, IDLE} state_t;

  function automatic logic legal(input logic [1:0] size, input logic [NB_ADDRESS-1:0] addr);
    return size == SZ_BYTE ? 1'b1 :
           size == SZ_HALF ? ~addr[0] :
           size == SZ_WORD ? addr[1:0] == 2'b00 :
           (NB_DATA_BUS == 64) && addr[2:0] == 3'b000;
  endfunction

  function automatic int size_bits(input logic [1:0] size);
    return size == SZ_BYTE ? 8 : size == SZ_HALF ? 16 : size == SZ_WORD ? 32 : NB_DATA_BUS;
  endfunction

  logic [NB_DATA_BUS-1:0] mem [N_WORDS];

  state_t                 state_q, state_d;
  logic [NB_IDX-1:0]      cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   ld_v_q, ld_v_d;
  logic [NB_DATA_BUS-1:0] ld_word_q, ld_word_d;
  logic [LANE_BITS-1:0]   ld_off_q, ld_off_d;
  logic [1:0]             ld_size_q, ld_size_d;
  logic                   ld_sgn_q, ld_sgn_d;
  logic                   mis1_q, mis1_d;
  logic [NB_DATA_BUS-1:0] r_data_q, r_data_d;
  logic                   r_valid_q, r_valid_d;
  logic                   misaligned_q, misaligned_d;

  logic                   idle, r_ok, w_ok;
  logic [NB_IDX-1:0]      r_idx, w_idx;
  logic [NB_BYTES-1:0]    w_be;
  logic [NB_DATA_BUS-1:0] w_rep, sh, lo_mask, ext;
  logic                   sgn;
  int                     sb;

  assign idle  = state_q == IDLE && !i_reset;
  assign r_ok  = idle && bus.i_r_en && legal(bus.i_r_size, bus.i_r_addr);
  assign w_ok  = idle && bus.i_w_en && legal(bus.i_w_size, bus.i_w_addr);
  assign r_idx = bus.i_r_addr[NB_ADDRESS-1:LANE_BITS];
  assign w_idx = bus.i_w_addr[NB_ADDRESS-1:LANE_BITS];

  always_comb begin
    w_be  = NB_BYTES'((1 << (size_bits(bus.i_w_size) / 8)) - 1) << bus.i_w_addr[LANE_BITS-1:0];
    w_rep = bus.i_w_size == SZ_BYTE ? {NB_BYTES{bus.i_w_data[7:0]}} :
            bus.i_w_size == SZ_HALF ? {(NB_BYTES/2){bus.i_w_data[15:0]}} :
            bus.i_w_size == SZ_WORD ? {(NB_BYTES/4){bus.i_w_data[31:0]}} : bus.i_w_data;
  end

  // Loaded lanes are right-justified, then everything above the access size is filled with the sign or zero.
  always_comb begin
    sh      = ld_word_q >> {ld_off_q, 3'b000};
    sb      = size_bits(ld_size_q);
    lo_mask = {NB_DATA_BUS{1'b1}} >> (NB_DATA_BUS - sb);
    sgn     = ld_sgn_q & sh[sb-1];
    ext     = (sh & lo_mask) | ({NB_DATA_BUS{sgn}} & ~lo_mask);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == NB_IDX'(N_WORDS-1) ? IDLE : CLEAR;
    end
    busy_d       = state_d == CLEAR;
    ld_v_d       = r_ok;
    ld_word_d    = r_ok ? mem[r_idx] : ld_word_q;
    ld_off_d     = r_ok ? bus.i_r_addr[LANE_BITS-1:0] : ld_off_q;
    ld_size_d    = r_ok ? bus.i_r_size : ld_size_q;
    ld_sgn_d     = r_ok ? bus.i_r_signed : ld_sgn_q;
    mis1_d       = idle && ((bus.i_r_en && !legal(bus.i_r_size, bus.i_r_addr)) ||
                            (bus.i_w_en && !legal(bus.i_w_size, bus.i_w_addr)));
    r_valid_d    = ld_v_q;
    r_data_d     = ld_v_q ? ext : r_data_q;
    misaligned_d = mis1_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cnt_q        <= '0;
      busy_q       <= CLEAR_ON_RESET;
      ld_v_q       <= 1'b0;
      ld_word_q    <= '0;
      ld_off_q     <= '0;
      ld_size_q    <= '0;
      ld_sgn_q     <= 1'b0;
      mis1_q       <= 1'b0;
      r_data_q     <= '0;
      r_valid_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      ld_v_q       <= ld_v_d;
      ld_word_q    <= ld_word_d;
      ld_off_q     <= ld_off_d;
      ld_size_q    <= ld_size_d;
      ld_sgn_q     <= ld_sgn_d;
      mis1_q       <= mis1_d;
      r_data_q     <= r_data_d;
      r_valid_q    <= r_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Byte-enabled write; disabled lanes keep their contents, so no read-modify-write is needed.
  always_ff @(posedge i_clk) begin
    if (state_q == CLEAR && !i_reset)
      mem[cnt_q] <= '0;
    else if (w_ok)
      for (int b = 0; b < NB_BYTES; b++)
        if (w_be[b]) mem[w_idx][8*b +: 8] <= w_rep[8*b +: 8];
  end

  assign bus.o_r_data     = r_data_q;
  assign bus.o_r_valid    = r_valid_q;
  assign bus.o_misaligned = misaligned_q;
  assign bus.o_busy       = busy_q;

`ifdef DATA_MEMORY_DEBUG_PORT_EN
  logic [NB_DATA_BUS-1:0] dbg_data_q, dbg_data_d;
  logic                   dbg_valid_q, dbg_valid_d;

  always_comb begin
    dbg_valid_d = bus.i_dbg_en;
    dbg_data_d  = bus.i_dbg_en ? mem[bus.i_dbg_addr] : dbg_data_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      dbg_data_q  <= dbg_data_d;
      dbg_valid_q <= dbg_valid_d;
    end
  end

  assign bus.o_dbg_data  = dbg_data_q;
  assign bus.o_dbg_valid = dbg_valid_q;
`endif
endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: directed vector table plus clear/reset sequences for data_memory_lsu.
module tb_data_memory_lsu;
  localparam int NB = 32;
  localparam int NW = 64;
  localparam int NA = 8;
  localparam logic [1:0] W = 2'b00, H = 2'b01, D = 2'b10, B = 2'b11;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  data_memory_lsu_if #(.NB_DATA_BUS(NB), .NB_ADDRESS(NA)) bus ();
  data_memory_lsu #(.NB_DATA_BUS(NB), .N_WORDS(NW), .CLEAR_ON_RESET(1'b1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus)
  );

  typedef struct {
    logic        w_en;
    logic [7:0]  w_addr;
    logic [1:0]  w_size;
    logic [31:0] w_data;
    logic        r_en;
    logic [7:0]  r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t v [21];

  function automatic vec_t mk(input logic we, input logic [7:0] wa, input logic [1:0] ws, input logic [31:0] wd,
                              input logic re, input logic [7:0] ra, input logic [1:0] rs, input logic sg,
                              input logic ev, input logic [31:0] ed, input logic em);
    vec_t x;
    x.w_en = we; x.w_addr = wa; x.w_size = ws; x.w_data = wd;
    x.r_en = re; x.r_addr = ra; x.r_size = rs; x.r_signed = sg;
    x.e_valid = ev; x.e_data = ed; x.e_mis = em;
    return x;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.i_w_en = x.w_en; bus.i_w_addr = x.w_addr; bus.i_w_size = x.w_size; bus.i_w_data = x.w_data;
    bus.i_r_en = x.r_en; bus.i_r_addr = x.r_addr; bus.i_r_size = x.r_size; bus.i_r_signed = x.r_signed;
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, W, 0, 0, 0, W, 0, 0, 0, 0));
  endtask

  task automatic apply(input vec_t x, input string name);
    drive(x);
    tick();
    idle_inputs();
    check({name, "_pre_valid"}, bus.o_r_valid, 0);
    check({name, "_pre_mis"}, bus.o_misaligned, 0);
    tick();
    check({name, "_valid"}, bus.o_r_valid, x.e_valid);
    check({name, "_data"}, bus.o_r_data, x.e_data);
    check({name, "_mis"}, bus.o_misaligned, x.e_mis);
  endtask

  task automatic count_busy(input bit reqs, output int n, output int strobes);
    n = 1;
    strobes = 0;
    if (reqs) drive(mk(1, 8'h00, W, 32'h0BADF00D, 1, 8'h21, W, 0, 0, 0, 0));
    while (bus.o_busy && n < 200) begin
      tick();
      if (bus.o_r_valid || bus.o_misaligned) strobes++;
      if (bus.o_busy) n++;
    end
    idle_inputs();
  endtask

  initial begin
    int n, s, st;
`ifdef DATA_MEMORY_DEBUG_PORT_EN
    bus.i_dbg_en = 1'b0;
    bus.i_dbg_addr = '0;
`endif
    v[0]  = mk(0, 8'h00, W, 32'h0,        1, 8'hFC, W, 0, 1, 32'h00000000, 0);
    v[1]  = mk(1, 8'h10, W, 32'h11223344, 0, 8'h00, W, 0, 0, 32'h00000000, 0);
    v[2]  = mk(1, 8'h11, B, 32'h000000AA, 0, 8'h00, W, 0, 0, 32'h00000000, 0);
    v[3]  = mk(0, 8'h00, W, 32'h0,        1, 8'h10, W, 0, 1, 32'h1122AA44, 0);
    v[4]  = mk(1, 8'h12, H, 32'h00008001, 0, 8'h00, W, 0, 0, 32'h1122AA44, 0);
    v[5]  = mk(0, 8'h00, W, 32'h0,        1, 8'h12, H, 1, 1, 32'hFFFF8001, 0);
    v[6]  = mk(0, 8'h00, W, 32'h0,        1, 8'h12, H, 0, 1, 32'h00008001, 0);
    v[7]  = mk(0, 8'h00, W, 32'h0,        1, 8'h02, W, 0, 0, 32'h00008001, 1);
    v[8]  = mk(1, 8'h05, H, 32'h00005555, 0, 8'h00, W, 0, 0, 32'h00008001, 1);
    v[9]  = mk(0, 8'h00, W, 32'h0,        1, 8'h04, W, 0, 1, 32'h00000000, 0);
    v[10] = mk(0, 8'h00, W, 32'h0,        1, 8'h10, D, 0, 0, 32'h00000000, 1);
    v[11] = mk(1, 8'h20, W, 32'h00000001, 0, 8'h00, W, 0, 0, 32'h00000000, 0);
    v[12] = mk(1, 8'h20, W, 32'hDEADBEEF, 1, 8'h20, W, 0, 1, 32'h00000001, 0);
    v[13] = mk(0, 8'h00, W, 32'h0,        1, 8'h20, W, 0, 1, 32'hDEADBEEF, 0);
    v[14] = mk(0, 8'h00, W, 32'h0,        1, 8'h23, B, 1, 1, 32'hFFFFFFDE, 0);
    v[15] = mk(0, 8'h00, W, 32'h0,        1, 8'h21, B, 0, 1, 32'h000000BE, 0);
    v[16] = mk(0, 8'h00, W, 32'h0,        1, 8'h10, W, 0, 1, 32'h8001AA44, 0);
    v[17] = mk(1, 8'h30, W, 32'hCAFEF00D, 1, 8'h31, W, 0, 0, 32'h8001AA44, 1);
    v[18] = mk(0, 8'h00, W, 32'h0,        1, 8'h30, W, 0, 1, 32'hCAFEF00D, 0);
    v[19] = mk(1, 8'h22, W, 32'h12345678, 1, 8'h32, H, 0, 1, 32'h0000CAFE, 1);
    v[20] = mk(0, 8'h00, W, 32'h0,        1, 8'h20, W, 0, 1, 32'hDEADBEEF, 0);

    idle_inputs();
    i_reset = 1'b1;
    tick();
    tick();
    check("rst_busy", bus.o_busy, 1);
    check("rst_data", bus.o_r_data, 0);
    check("rst_valid", bus.o_r_valid, 0);
    check("rst_mis", bus.o_misaligned, 0);
    i_reset = 1'b0;
    count_busy(0, n, s);
    check("clear_len", n, 64);

    for (int i = 0; i < 21; i++) begin
      apply(v[i], $sformatf("v%0d", i));
      check($sformatf("v%0d_busy", i), bus.o_busy, 0);
    end

    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    st = 0;
    drive(mk(1, 8'h00, W, 32'h0BADF00D, 1, 8'h02, W, 0, 0, 0, 0));
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.o_r_valid || bus.o_misaligned || !bus.o_busy) st++;
    end
    check("midclear_strobes", st, 0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("rerst_busy", bus.o_busy, 1);
    count_busy(1, n, s);
    check("reclear_len", n, 64);
    check("busy_strobes", s, 0);
    apply(mk(0, 8'h00, W, 32'h0, 1, 8'h00, W, 0, 1, 32'h00000000, 0), "post_clear_w0");
    apply(mk(0, 8'h00, W, 32'h0, 1, 8'h10, W, 0, 1, 32'h00000000, 0), "post_clear_w10");
    apply(mk(0, 8'h00, W, 32'h0, 1, 8'h30, W, 0, 1, 32'h00000000, 0), "post_clear_w30");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Parametrised successor to the datapath's 32-bit data memory, sitting in the MEM stage between the ALU result/store-data path and the write-back mux.
- Adds:
  - configurable bus width and depth
  - byte-enable stores, with no read-modify-write cycle
  - registered loads with a valid strobe and sign/zero extension
  - misalignment reporting
  - a post-reset clear sequencer

Parameters:
- NB_DATA_BUS, 32, data bus width; legal values 32 or 64.
- N_WORDS, 64, memory depth in bus-width words.
- NB_ADDRESS, $clog2(N_WORDS)+$clog2(NB_DATA_BUS/8), byte-address width.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip the clear and go straight to IDLE.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_r_en  in  1  load request; sampled on posedge.
- i_r_addr  in  NB_ADDRESS  load byte address.
- i_r_size  in  2  load size code: 00 word32, 01 half, 11 byte, 10 dword64.
- i_r_signed  in  1  1 = sign-extend the loaded value, 0 = zero-extend.
- i_w_en  in  1  store request.
- i_w_addr  in  NB_ADDRESS  store byte address.
- i_w_size  in  2  store size code, same encoding as i_r_size.
- i_w_data  in  NB_DATA_BUS  store data; the value is taken from the low-order bits.
- o_r_data  out  NB_DATA_BUS  load result, right-justified and extended.
- o_r_valid  out  1  one-cycle strobe marking o_r_data as new.
- o_misaligned  out  1  one-cycle strobe, pulsed when a rejected access is flagged.
- o_busy  out  1  high while the clear sequencer runs.

Behaviour:
- Address split:
  - word index = addr[NB_ADDRESS-1:LANE_BITS], where LANE_BITS = $clog2(NB_DATA_BUS/8).
  - lane offset = addr[LANE_BITS-1:0].
- Alignment rules:
  - byte: always legal.
  - half: requires addr[0]==0.
  - word32: requires addr[1:0]==0.
  - dword64: legal only when NB_DATA_BUS==64 and addr[2:0]==0; otherwise illegal.
- Store:
  - A legal store builds a byte-enable mask from size and offset, replicates the data into the lanes, and writes only the enabled bytes at the posedge where it is accepted.
  - No extra cycle; the untouched bytes are preserved.
- Load:
  - A legal load reads at posedge N.
  - At posedge N+1: o_r_data = selected lanes shifted to bit 0 and extended per i_r_signed; o_r_valid=1 for exactly that cycle.
  - When no load completes, o_r_data holds its last value.
- Illegal access (misaligned or illegal size):
  - No memory update and no o_r_valid.
  - o_misaligned=1 for one cycle after acceptance.
  - A simultaneous legal access on the other port still executes.
- Same-word load and store in the same cycle: read-first; the load returns the pre-store data.
- FSM CLEAR/IDLE:
  - i_reset → CLEAR (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0); clear counter = 0.
  - CLEAR: writes 0 to word[counter] each cycle and increments the counter; o_busy=1; all requests are ignored, with no strobes.
  - Counter == N_WORDS-1 → IDLE after that word is written, so a clear takes N_WORDS cycles.
  - Reset asserted mid-clear restarts the clear from word 0.
- Reset values, applied at the reset posedge:
  - o_r_data=0, o_r_valid=0, o_misaligned=0.
  - o_busy=1 if CLEAR_ON_RESET, else 0.
  - Array contents are not reset directly; the clear sequencer zeroes them.
- Widths:
  - Extension fills bits [NB_DATA_BUS-1:size_bits].
  - A word32 load on a 64-bit bus extends from bit 31.

Optional Feature:
- Macro: DATA_MEMORY_DEBUG_PORT_EN.
- When defined, adds:
  - inputs i_dbg_en (1 bit) and i_dbg_addr (word index, $clog2(N_WORDS) bits).
  - outputs o_dbg_data (NB_DATA_BUS) and o_dbg_valid (1).
- Debug-port behaviour:
  - Full-word read, one-cycle latency, served even during CLEAR, where it returns the current contents.
  - A debug read never blocks or delays the pipeline ports.
  - Reset value: o_dbg_data=0, o_dbg_valid=0.
- When undefined, these ports and their logic do not exist.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, N_WORDS=64 → o_busy=1 for exactly 64 cycles, then 0; a load of word32 @0x0FC returns 0x00000000 with o_r_valid.
2. Store word 0x11223344 @0x10, then byte store 0xAA @0x11, then word load @0x10 → o_r_data=0x1122AA44, valid one cycle after the load request.
3. Half load @0x12 of 0x8001 with i_r_signed=1 → 0xFFFF8001; with i_r_signed=0 → 0x00008001.
4. Word load @0x02 and half store @0x05 → o_misaligned pulses once for each, no o_r_valid, memory unchanged; dword size on a 32-bit bus → o_misaligned.
5. Same-cycle store 0xDEADBEEF and load, both @0x20, where the word held 0x01 → load returns 0x00000001; the next load returns 0xDEADBEEF.
6. Reset asserted at clear count 30 → counter restarts at 0 and o_busy stays high for 64 cycles after reset deasserts; requests during busy produce no strobes.
